// File: rtl/led_pkg.sv
// Shared constants for the LED pattern driver: mode encodings, LED count,
// breathing direction codes and the running-light decoder.
package led_pkg;

  localparam int LED_N = 3;

  localparam logic [2:0] MODE_OFF     = 3'd0;
  localparam logic [2:0] MODE_STATIC  = 3'd1;
  localparam logic [2:0] MODE_BLINK   = 3'd2;
  localparam logic [2:0] MODE_RUN     = 3'd3;
  localparam logic [2:0] MODE_BREATHE = 3'd4;
  localparam logic [2:0] MODE_ALT     = 3'd5;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Ring index 0/1/2 lights LED 0/1/2; index 3 never occurs.
  function automatic logic [LED_N-1:0] ring_onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Pattern-tick prescaler: one-cycle strobe every CLK_DIV clocks, restartable
// from zero through clear (which also suppresses the strobe in that cycle).
module led_tick_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] div_cnt;

  assign tick = (div_cnt == DIV_LAST) && !clear;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (clear || div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_ONE;
    end
  end

endmodule

// File: rtl/led_pattern_driver.sv
// Drives the three board LEDs from the mode count and debounced keys:
// per-LED enable toggled by key presses, masked onto a mode-selected pattern.
module led_pattern_driver
  import led_pkg::*;
#(
  parameter int CLK_DIV  = 16,
  parameter int PWM_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       count,
  input  logic [LED_N-1:0] key_led,
  output logic [LED_N-1:0] led,
  output logic             tick
);

  localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  logic [LED_N-1:0]    en;
  logic [LED_N-1:0]    key_prev;
  logic [2:0]          count_prev;
  logic [2:0]          step_cnt;
  logic [1:0]          ring_idx;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;
  logic                dir;

  logic                mode_change;
  logic [LED_N-1:0]    press;
  logic [2:0]          step_eff;
  logic [1:0]          ring_eff;
  logic [PWM_BITS-1:0] duty_eff;
  logic [LED_N-1:0]    pat;

  assign mode_change = (count != count_prev);
  assign press       = key_prev & ~key_led;

  led_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (mode_change),
    .tick  (tick)
  );

  // In the change cycle the pattern already uses the cleared state, so the
  // new mode starts from its first step one clock after count moves.
  assign step_eff = mode_change ? '0 : step_cnt;
  assign ring_eff = mode_change ? '0 : ring_idx;
  assign duty_eff = mode_change ? '0 : duty;

  // NOTE: every variable written here gets a default first, so no path can
  // leave it holding its old value and no latch is inferred.
  always_comb begin
    pat = '0;
    case (count)
      MODE_OFF:     pat = '0;
      MODE_BLINK:   pat = step_eff[2] ? '0 : '1;
      MODE_RUN:     pat = ring_onehot(ring_eff);
      MODE_BREATHE: pat = (pwm_cnt < duty_eff) ? '1 : '0;
      MODE_ALT:     pat = step_eff[2] ? 3'b010 : 3'b101;
      default:      pat = '1;
    endcase
  end

  // NOTE: only control registers exist here, so all of them take the async
  // reset; there is no storage array that would be left unreset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led        <= '0;
      en         <= '1;
      key_prev   <= '1;
      count_prev <= '0;
      step_cnt   <= '0;
      ring_idx   <= '0;
      pwm_cnt    <= '0;
      duty       <= '0;
      dir        <= DIR_UP;
    end else begin
      led        <= pat & en;
      en         <= en ^ press;
      key_prev   <= key_led;
      count_prev <= count;
      pwm_cnt    <= pwm_cnt + PWM_ONE;

      if (mode_change) begin
        step_cnt <= '0;
        ring_idx <= '0;
        duty     <= '0;
        dir      <= DIR_UP;
      end else if (tick) begin
        step_cnt <= step_cnt + 3'd1;
        // Ring advances on every second tick: leaving an odd step.
        if (step_cnt[0]) begin
          ring_idx <= (ring_idx == 2'd2) ? 2'd0 : ring_idx + 2'd1;
        end
        // The turnaround tick only flips direction; duty holds there.
        if (dir == DIR_UP) begin
          if (duty == DUTY_MAX) dir <= DIR_DOWN;
          else                  duty <= duty + PWM_ONE;
        end else begin
          if (duty == '0) dir <= DIR_UP;
          else            duty <= duty - PWM_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Scoreboard bench for led_pattern_driver: a cycle-level reference model
// derived from elapsed ticks predicts led/tick; a monitor compares each cycle.
module tb_led_pattern_driver;

  localparam int CLK_DIV  = 16;
  localparam int PWM_BITS = 4;
  localparam int PWM_N    = 1 << PWM_BITS;

  bit         clk = 1'b0;
  logic       rst;
  logic [2:0] count;
  logic [2:0] key_led;
  logic [2:0] led;
  logic       tick;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       tick;
    logic [2:0] led;
  } exp_t;

  exp_t sb[$];

  led_pattern_driver #(.CLK_DIV(CLK_DIV), .PWM_BITS(PWM_BITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .count   (count),
    .key_led (key_led),
    .led     (led),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. k = cycles since the last mode change (0 = change
  // cycle), j = cycles since reset release. Pattern state follows from the
  // number of ticks elapsed since the change.
  int         m_k, m_j, m_n, m_kk, m_tri;
  int         m_step, m_ring, m_duty, m_pwm;
  logic [2:0] m_en, m_kprev, m_cprev, m_led, m_pat;
  logic       m_tick;

  always @(negedge clk) begin
    if (!rst) begin
      m_en = 3'b111; m_kprev = 3'b111; m_cprev = 3'b000;
      m_k = 1; m_j = 0; m_led = 3'b000;
      sb.push_back('{tick: 1'b0, led: 3'b000});
    end else begin
      m_kk   = (count != m_cprev) ? 0 : m_k;
      m_n    = (m_kk == 0) ? 0 : (m_kk - 1) / CLK_DIV;
      m_tick = (m_kk >= 1) && ((m_kk - 1) % CLK_DIV == CLK_DIV - 1);
      m_step = m_n % 8;
      m_ring = (m_n / 2) % 3;
      m_tri  = m_n % (2 * PWM_N);
      m_duty = (m_tri < PWM_N) ? m_tri : (2 * PWM_N - 1 - m_tri);
      m_pwm  = m_j % PWM_N;
      case (count)
        3'd0:    m_pat = 3'b000;
        3'd2:    m_pat = (m_step < 4) ? 3'b111 : 3'b000;
        3'd3:    m_pat = (m_ring == 0) ? 3'b001 : (m_ring == 1) ? 3'b010 : 3'b100;
        3'd4:    m_pat = (m_pwm < m_duty) ? 3'b111 : 3'b000;
        3'd5:    m_pat = (m_step < 4) ? 3'b101 : 3'b010;
        default: m_pat = 3'b111;
      endcase
      sb.push_back('{tick: m_tick, led: m_led});
      m_led   = m_pat & m_en;
      m_en    = m_en ^ (m_kprev & ~key_led);
      m_kprev = key_led;
      m_cprev = count;
      m_k     = m_kk + 1;
      m_j     = m_j + 1;
    end
  end

  // Monitor: one expected record per cycle, compared mid-low-phase.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("led", {29'd0, led}, {29'd0, e.led});
      check("tick", {31'd0, tick}, {31'd0, e.tick});
    end
  end

  task automatic drive(input logic [2:0] c, input logic [2:0] k, input int n);
    @(posedge clk);
    #1;
    count   = c;
    key_led = k;
    repeat (n - 1) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; count = 3'd1; key_led = 3'b111;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("led_in_reset", {29'd0, led}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Static mode, tick period, key press held 20 clk, second press.
    drive(3'd1, 3'b111, 40);
    drive(3'd1, 3'b011, 20);
    drive(3'd1, 3'b111, 10);
    drive(3'd1, 3'b011, 3);
    drive(3'd1, 3'b111, 10);

    // Blink for a full period plus restart.
    drive(3'd2, 3'b111, 300);

    // Running light with en[0] cleared.
    drive(3'd3, 3'b110, 2);
    drive(3'd3, 3'b111, 250);

    // Breathing through a full up/down ramp.
    drive(3'd4, 3'b111, 600);

    // 3 -> 5 mid-step with a simultaneous press.
    drive(3'd3, 3'b111, 70);
    drive(3'd5, 3'b101, 4);
    drive(3'd5, 3'b111, 150);

    // Randomized modes and key activity, including multi-bit presses.
    for (int i = 0; i < 60; i++) begin
      drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom_range(1, 60));
    end

    // Asynchronous reset in the middle of breathing.
    drive(3'd4, 3'b111, 200);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async_rst_led", {29'd0, led}, 32'd0);
    check("async_rst_tick", {31'd0, tick}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    drive(3'd4, 3'b111, 100);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
